sharpen_acc17: RTL and testbench

//  Sequential 3x3 sharpening-kernel accumulator for the DLX image-sharpening extension.
//  - Takes nine 8-bit pixels of one window, one per handshake beat, in raster order.
//  - Computes RESULT = CW*p[4] - EW*(sum of the 8 neighbours) as a 17-bit signed value.
//  - Sits directly upstream of the 17-bit result mux: RESULT drives the mux's IN1.
//    PIX_SAT is the 8-bit clamped pixel used for write-back.

---
 rtl/sharpen_acc17_pkg.sv | 18 +
 rtl/sharpen_acc17_if.sv | 24 ++
 rtl/sharpen_acc17_sat_clamp17to8.sv | 20 ++
 rtl/sharpen_acc17.sv | 109 ++++++++++
 tb/tb_sharpen_acc17.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sharpen_acc17_pkg.sv
// Shared constants and types for the 3x3 sharpening accumulator.
package sharpen_acc17_pkg;

    localparam int KERNEL_TAPS = 9;
    localparam int CENTRE_IDX  = 4;
    localparam int ACCW        = 17;
    localparam int PIXW        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef logic signed [ACCW-1:0] acc_t;
    typedef logic        [PIXW-1:0] pix_t;

endpackage

// File: rtl/sharpen_acc17_if.sv
// Pixel-in / result-out handshake bundle for sharpen_acc17.
interface sharpen_acc17_if;
    import sharpen_acc17_pkg::*;

    logic start;
    pix_t pix_dat;
    logic pix_vld;
    logic pix_rdy;
    acc_t res_dat;
    pix_t sat_dat;
    logic res_vld;
    logic res_ack;

    modport master (
        output start, pix_dat, pix_vld, res_ack,
        input  pix_rdy, res_dat, sat_dat, res_vld
    );

    modport slave (
        input  start, pix_dat, pix_vld, res_ack,
        output pix_rdy, res_dat, sat_dat, res_vld
    );

endinterface

// File: rtl/sharpen_acc17_sat_clamp17to8.sv
// Combinational clamp of a signed 17-bit value to an unsigned 8-bit pixel (0..255).
// Zero latency; no handshake.
module sharpen_acc17_sat_clamp17to8
    import sharpen_acc17_pkg::*;
(
    input  acc_t val_i,
    output pix_t sat_o
);

    always_comb begin
        if (val_i[ACCW-1]) begin
            sat_o = '0;
        end else if (|val_i[ACCW-2:PIXW]) begin
            sat_o = '1;
        end else begin
            sat_o = val_i[PIXW-1:0];
        end
    end

endmodule

// File: rtl/sharpen_acc17.sv
// 3x3 sharpening accumulator: nine pixels in raster order, RESULT = CW*centre - EW*neighbours.
// Result registered on the 9th-beat edge and held in DONE until res_ack; pix_rdy is high throughout ACC.
module sharpen_acc17
    import sharpen_acc17_pkg::*;
#(
    parameter int unsigned CW   = 9,
    parameter int unsigned EW   = 1,
    parameter int unsigned PIXW = 8
)
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    sharpen_acc17_if.slave  bus
);

    localparam logic [ACCW-1:0] CW_W = ACCW'(CW);
    localparam logic [ACCW-1:0] EW_W = ACCW'(EW);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    acc_t            acc_q, acc_d;
    acc_t            result_q, result_d;
    pix_t            sat_q, sat_d;

    logic            beat, last_beat, centre_beat, win_start;
    logic [ACCW-1:0] pix_ext, term;
    acc_t            acc_nxt;
    pix_t            sat_c;

    assign beat        = bus.pix_vld && (state_q == ST_ACC);
    assign centre_beat = (cnt_q == 4'(CENTRE_IDX));
    assign last_beat   = beat && (cnt_q == 4'(KERNEL_TAPS - 1));
    assign win_start   = bus.start &&
                         ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.res_ack));

    // Pixels are unsigned: widen with zeros before weighting so the subtraction stays exact.
    always_comb begin
        pix_ext = {{(ACCW-PIXW){1'b0}}, bus.pix_dat};
        term    = centre_beat ? (pix_ext * CW_W) : (pix_ext * EW_W);
        acc_nxt = centre_beat ? (acc_q + acc_t'(term)) : (acc_q - acc_t'(term));
    end

    sharpen_acc17_sat_clamp17to8 u_clamp (
        .val_i (acc_nxt),
        .sat_o (sat_c)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_ACC;
            ST_ACC:  if (last_beat) state_d = ST_DONE;
            ST_DONE: if (bus.res_ack) state_d = bus.start ? ST_ACC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.pix_rdy = (state_q == ST_ACC);
        bus.res_vld = (state_q == ST_DONE);
        bus.res_dat = result_q;
        bus.sat_dat = sat_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        sat_d    = sat_q;
        if (win_start) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (beat) begin
            cnt_d = cnt_q + 4'd1;
            acc_d = acc_nxt;
            if (last_beat) begin
                result_d = acc_nxt;
                sat_d    = sat_c;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            sat_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

    a_cw_range: assert property (@(posedge clk_i) (CW >= 1) && (CW <= 127));
    a_ew_range: assert property (@(posedge clk_i) (EW <= 15));
    a_pixw:     assert property (@(posedge clk_i) (PIXW == 8));

endmodule

// File: tb/tb_sharpen_acc17.sv
// Self-checking bench for sharpen_acc17: vector table plus hand-written hold/back-to-back/reset sequences.
module tb_sharpen_acc17;
    import sharpen_acc17_pkg::*;

    typedef struct {
        logic [8:0][7:0] pix;
        logic [8:0]      gap;
        logic [16:0]     exp_res;
        logic [7:0]      exp_sat;
    } vec_t;

    typedef struct packed {
        logic [16:0] res;
        logic [7:0]  sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    sharpen_acc17_if bus ();

    sharpen_acc17 #(.CW(9), .EW(1), .PIXW(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    function automatic logic [8:0][7:0] uni(input logic [7:0] c, input logic [7:0] n);
        logic [8:0][7:0] p;
        for (int i = 0; i < 9; i++) p[i] = (i == 4) ? c : n;
        return p;
    endfunction

    function automatic vec_t mk(input logic [8:0][7:0] p, input logic [8:0] g,
                                input int r, input int s);
        vec_t v;
        v.pix     = p;
        v.gap     = g;
        v.exp_res = 17'(r);
        v.exp_sat = 8'(s);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_window(input vec_t v, input bit do_start);
        if (do_start) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        for (int b = 0; b < 9; b++) begin
            if (v.gap[b]) begin
                repeat (3) begin
                    bus.pix_vld = 1'b0;
                    bus.pix_dat = 8'($urandom);
                    tick();
                    chk("rdy_in_gap", {31'b0, bus.pix_rdy}, 32'd1);
                end
            end
            chk("rdy_beat", {31'b0, bus.pix_rdy}, 32'd1);
            bus.pix_dat = v.pix[b];
            bus.pix_vld = 1'b1;
            if (b == 8) exp_q.push_back('{res: v.exp_res, sat: v.exp_sat});
            tick();
            if (b < 8) chk("vld_early", {31'b0, bus.res_vld}, 32'd0);
        end
        bus.pix_vld = 1'b0;
        chk("vld_latency", {31'b0, bus.res_vld}, 32'd1);
        for (int t = 0; t < 20 && !bus.res_vld; t++) tick();
        if (!bus.res_vld) begin
            chk("res_timeout", 32'd0, 32'd1);
        end else if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", {15'b0, bus.res_dat}, {15'b0, e.res});
            chk("pix_sat", {24'b0, bus.sat_dat}, {24'b0, e.sat});
        end
    endtask

    task automatic ack_to_idle();
        bus.res_ack = 1'b1;
        tick();
        bus.res_ack = 1'b0;
        chk("vld_after_ack", {31'b0, bus.res_vld}, 32'd0);
        chk("rdy_after_ack", {31'b0, bus.pix_rdy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t    v;
        logic [8:0][7:0] ramp;
        for (int i = 0; i < 9; i++) ramp[i] = 8'(i + 1);
        vecs[0]  = mk(uni(8'd100, 8'd100), 9'b0,          100,   100);
        vecs[1]  = mk(uni(8'd255, 8'd0),   9'b0,          2295,  255);
        vecs[2]  = mk(uni(8'd0,   8'd255), 9'b0,          -2040, 0);
        vecs[3]  = mk(uni(8'd100, 8'd100), 9'b010010010,  100,   100);
        vecs[4]  = mk(ramp,                9'b0,          5,     5);
        vecs[5]  = mk(uni(8'd31,  8'd3),   9'b0,          255,   255);
        vecs[6]  = mk(uni(8'd32,  8'd4),   9'b0,          256,   255);
        vecs[7]  = mk(uni(8'd8,   8'd9),   9'b0,          0,     0);
        vecs[8]  = mk(uni(8'd7,   8'd8),   9'b0,          -1,    0);
        vecs[9]  = mk(uni(8'd200, 8'd10),  9'b0,          1720,  255);
        vecs[10] = mk(uni(8'd20,  8'd30),  9'b0,          -60,   0);

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.pix_dat = '0;
        bus.pix_vld = 1'b0;
        bus.res_ack = 1'b0;
        repeat (3) tick();
        chk("rst_result", {15'b0, bus.res_dat}, 32'd0);
        chk("rst_sat",    {24'b0, bus.sat_dat}, 32'd0);
        chk("rst_rdy",    {31'b0, bus.pix_rdy}, 32'd0);
        chk("rst_vld",    {31'b0, bus.res_vld}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_rdy", {31'b0, bus.pix_rdy}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            send_window(vecs[i], 1'b1);
            ack_to_idle();
            chk("result_held_idle", {15'b0, bus.res_dat}, {15'b0, vecs[i].exp_res});
        end

        // Hold DONE without ack; a START during the hold must be ignored.
        send_window(vecs[0], 1'b1);
        for (int c = 0; c < 5; c++) begin
            bus.start = (c == 2);
            tick();
            chk("hold_vld", {31'b0, bus.res_vld}, 32'd1);
            chk("hold_result", {15'b0, bus.res_dat}, 32'd100);
            chk("hold_sat", {24'b0, bus.sat_dat}, 32'd100);
        end
        bus.res_ack = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.res_ack = 1'b0;
        bus.start   = 1'b0;
        chk("b2b_rdy", {31'b0, bus.pix_rdy}, 32'd1);
        chk("b2b_vld", {31'b0, bus.res_vld}, 32'd0);
        send_window(mk(uni(8'd50, 8'd50), 9'b0, 50, 50), 1'b0);
        ack_to_idle();

        // Reset mid-window after four beats.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.pix_dat = 8'd10;
            bus.pix_vld = 1'b1;
            tick();
        end
        bus.pix_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", {15'b0, bus.res_dat}, 32'd0);
        chk("midrst_sat",    {24'b0, bus.sat_dat}, 32'd0);
        chk("midrst_rdy",    {31'b0, bus.pix_rdy}, 32'd0);
        chk("midrst_vld",    {31'b0, bus.res_vld}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        v = mk(uni(8'd10, 8'd10), 9'b0, 10, 10);
        send_window(v, 1'b1);
        ack_to_idle();

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
